bist_checker_3in: RTL and testbench
===================================

# bist_checker_3in

Built-in self-test engine for 3-input/1-output combinational gate circuits. It drives all eight input combinations into the device under test (DUT) in ascending order, which is the response-checking counterpart of a stimulus-driving testbench. It samples the DUT output for each vector and compares it against a golden truth table. It then reports pass/fail, an error count, a per-vector fail mask and the first failing vector. It sits beside a combinational lab circuit in synthesizable form, so the check runs on hardware without a simulator `$monitor`.

## Interface
Parameters:
- GOLDEN, 8'b1001_0000, expected DUT output; bit i = expected X for input vector {A,B,C} = i. Default is X = A & (B XNOR C).
- SETTLE, 1, cycles the vector is held before the sampling cycle; legal range 1..15.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a test run; sampled only in IDLE
- dut_a  output  1  DUT input A = vector bit 2
- dut_b  output  1  DUT input B = vector bit 1
- dut_c  output  1  DUT input C = vector bit 0
- dut_x  input  1  DUT output under test
- busy  output  1  high from start acceptance until done
- done  output  1  one-cycle pulse when the run completes
- pass  output  1  verdict, valid from done until the next accepted start
- err_count  output  4  number of failing vectors, 0..8
- fail_mask  output  8  bit i set if vector i mismatched
- first_fail  output  3  lowest failing vector index; 0 if none
- first_fail_valid  output  1  at least one mismatch recorded

## Operation
- FSM states are IDLE, APPLY, CHECK and FINISH.
- IDLE:
  - start=1 → APPLY, idx=0, settle counter=0.
  - The same edge clears err_count, fail_mask, first_fail, first_fail_valid and pass.
- APPLY:
  - {dut_a,dut_b,dut_c} = idx, registered, driven for the whole state.
  - The counter increments every cycle; when counter == SETTLE-1 → CHECK.
- CHECK lasts one cycle. The inputs stay driven. At its closing edge, dut_x is compared with GOLDEN[idx].
  - On mismatch: set fail_mask[idx] and increment err_count.
  - If first_fail_valid=0, also load first_fail=idx and set first_fail_valid.
  - If idx==7 → FINISH; otherwise idx+1 → APPLY with the counter cleared.
- FINISH lasts one cycle.
  - done=1 and pass=(err_count==0) are registered on entry.
  - Next state is IDLE. start is ignored in FINISH.
- err_count never exceeds 8, so no wrap occurs. It always equals popcount(fail_mask).
- start while busy has no effect and is not queued.
- dut_* hold the last vector (7) after a run until the next start or reset.

## Timing
- Reset (rst=1 at an edge), regardless of state:
  - state=IDLE, idx=0, dut_a/b/c=0.
  - busy=0, done=0, pass=0, err_count=0, fail_mask=0, first_fail=0, first_fail_valid=0.
- Reset mid-run aborts immediately. No done pulse is produced and results are cleared.
- Each vector occupies SETTLE+1 cycles. The DUT input is stable SETTLE+1 edges before dut_x is sampled.
- If start is accepted at edge k, done is high during the cycle following edge k+8·(SETTLE+1). With SETTLE=1 that is edge k+16.
- busy is high from edge k through the done cycle inclusive, and low in the cycle after.
- The earliest next start is accepted at the edge ending the IDLE cycle after FINISH.
- dut_x is sampled only at the edges closing CHECK. Glitches at other times are ignored.
- Verdict outputs (pass, err_count, fail_mask, first_fail*) are stable from the done cycle until the next accepted start or reset.

## Test plan
- Golden-correct DUT model (X = A&(B~^C)), SETTLE=1, start pulse:
  - done 16 cycles after acceptance; pass=1, err_count=0, fail_mask=8'h00, first_fail_valid=0.
  - Vectors observed on dut_* are 0..7 in order, each held 2 cycles.
- dut_x stuck at 0 → pass=0, err_count=2, fail_mask=8'h90, first_fail=4, first_fail_valid=1.
- dut_x stuck at 1 → pass=0, err_count=6, fail_mask=8'h6F, first_fail=0.
- SETTLE=3 with a correct DUT → done exactly 32 cycles after acceptance, pass=1.
- start held high continuously → runs back-to-back, one idle cycle between done and the next busy. Extra start pulses while busy do not restart or shorten the run.
- rst asserted during vector 5 of a run with dut_x stuck at 0:
  - Next cycle: all outputs at reset values, no done.
  - A subsequent run gives err_count=2 (not 3 or 4).

Source files
------------

// File: rtl/bist_checker_3in.sv
// BIST engine for a 3-input/1-output combinational circuit: sweeps all eight
// input vectors, compares the circuit output against a golden truth table and
// reports a verdict, error count, per-vector fail mask and first failing vector.
module bist_checker_3in #(
  parameter logic [7:0]  GOLDEN = 8'b1001_0000,
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_c,
  input  logic       dut_x,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_mask,
  output logic [2:0] first_fail,
  output logic       first_fail_valid
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned IDX_W   = 3;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(7);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] vec_q, vec_d;
  logic             busy_d, done_d, pass_d, ffv_d;
  logic [3:0]       err_d;
  logic [7:0]       mask_d;
  logic [IDX_W-1:0] ff_d;
  logic             mismatch_c;

  assign dut_a = vec_q[2];
  assign dut_b = vec_q[1];
  assign dut_c = vec_q[0];

  assign mismatch_c = (dut_x != GOLDEN[idx_q]);

  // Register file: FSM state, vector index, settle counter and all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      idx_q            <= '0;
      cnt_q            <= '0;
      vec_q            <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      fail_mask        <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      cnt_q            <= cnt_d;
      vec_q            <= vec_d;
      busy             <= busy_d;
      done             <= done_d;
      pass             <= pass_d;
      err_count        <= err_d;
      fail_mask        <= mask_d;
      first_fail       <= ff_d;
      first_fail_valid <= ffv_d;
    end
  end

  // Next-state and next-output logic; verdict registers hold unless updated.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    busy_d  = busy;
    done_d  = 1'b0;
    pass_d  = pass;
    err_d   = err_count;
    mask_d  = fail_mask;
    ff_d    = first_fail;
    ffv_d   = first_fail_valid;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = APPLY;
          idx_d   = '0;
          cnt_d   = '0;
          vec_d   = '0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = '0;
          mask_d  = '0;
          ff_d    = '0;
          ffv_d   = 1'b0;
        end
      end

      APPLY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == SETTLE_LAST) begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (mismatch_c) begin
          mask_d[idx_q] = 1'b1;
          err_d         = err_count + 4'd1;
          if (!first_fail_valid) begin
            ff_d  = idx_q;
            ffv_d = 1'b1;
          end
        end
        if (idx_q == IDX_LAST) begin
          state_d = FINISH;
          done_d  = 1'b1;
          pass_d  = (err_d == 4'd0);
        end else begin
          state_d = APPLY;
          idx_d   = idx_q + IDX_W'(1);
          vec_d   = idx_q + IDX_W'(1);
          cnt_d   = '0;
        end
      end

      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bist_checker_3in.sv
// Directed bench for bist_checker_3in: correct, stuck-at-0 and stuck-at-1
// circuits, a longer settle time, back-to-back runs and reset mid-run.
module tb_bist_checker_3in;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1;
  int         mode;

  logic       a0, b0, c0, x0, busy0, done0, pass0, ffv0;
  logic [3:0] err0;
  logic [7:0] mask0;
  logic [2:0] ff0;

  logic       a1, b1, c1, x1, busy1, done1, pass1, ffv1;
  logic [3:0] err1;
  logic [7:0] mask1;
  logic [2:0] ff1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Circuit under test: 0 = correct X = A&(B~^C), 1 = stuck at 0, 2 = stuck at 1.
  function automatic logic model(input logic a, input logic b, input logic c, input int m);
    case (m)
      1:       return 1'b0;
      2:       return 1'b1;
      default: return a & ~(b ^ c);
    endcase
  endfunction

  assign x0 = model(a0, b0, c0, mode);
  assign x1 = model(a1, b1, c1, mode);

  bist_checker_3in #(.GOLDEN(8'b1001_0000), .SETTLE(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .dut_a(a0), .dut_b(b0), .dut_c(c0), .dut_x(x0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_mask(mask0), .first_fail(ff0), .first_fail_valid(ffv0)
  );

  bist_checker_3in #(.GOLDEN(8'b1001_0000), .SETTLE(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .dut_a(a1), .dut_b(b1), .dut_c(c1), .dut_x(x1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_mask(mask1), .first_fail(ff1), .first_fail_valid(ffv1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start a run and wait for done; lat = cycles from acceptance edge to done.
  // seq_ok tracks the applied vector sequence and busy during the run.
  task automatic run(input int which, input bit keep_start, output int lat, output bit seq_ok);
    int   s;
    logic [2:0] vec;
    logic bsy, dn;
    s      = (which == 1) ? 3 : 1;
    lat    = -1;
    seq_ok = 1'b1;
    @(negedge clk);
    if (which == 1) start1 = 1'b1; else start0 = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!keep_start) begin
        start0 = 1'b0;
        start1 = 1'b0;
      end
      vec = (which == 1) ? {a1, b1, c1} : {a0, b0, c0};
      bsy = (which == 1) ? busy1 : busy0;
      dn  = (which == 1) ? done1 : done0;
      if (n < 8 * (s + 1) && vec != 3'(n / (s + 1))) seq_ok = 1'b0;
      if (bsy !== 1'b1) seq_ok = 1'b0;
      if (dn === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic check_verdict0(input string tag, input logic p, input logic [3:0] e,
                                input logic [7:0] m, input logic v, input logic [2:0] f);
    check({tag, "_pass"}, 32'(pass0), 32'(p));
    check({tag, "_err"},  32'(err0),  32'(e));
    check({tag, "_mask"}, 32'(mask0), 32'(m));
    check({tag, "_ffv"},  32'(ffv0),  32'(v));
    check({tag, "_ff"},   32'(ff0),   32'(f));
  endtask

  initial begin
    int lat;
    bit ok;
    bit quiet;

    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    mode   = 0;
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy0), 32'd0);
    check("rst_done",  32'(done0), 32'd0);
    check("rst_vec",   32'({a0, b0, c0}), 32'd0);
    check_verdict0("rst", 1'b0, 4'd0, 8'h00, 1'b0, 3'd0);
    rst = 1'b0;
    @(negedge clk);

    // Correct circuit, SETTLE=1
    mode = 0;
    run(0, 1'b0, lat, ok);
    check("good_lat", 32'(lat), 32'd16);
    check("good_seq", 32'(ok), 32'd1);
    check_verdict0("good", 1'b1, 4'd0, 8'h00, 1'b0, 3'd0);
    @(negedge clk);
    check("good_busy_after", 32'(busy0), 32'd0);
    check("good_done_pulse", 32'(done0), 32'd0);
    check("good_vec_hold",   32'({a0, b0, c0}), 32'd7);

    // Stuck at 0
    mode = 1;
    run(0, 1'b0, lat, ok);
    check("sa0_lat", 32'(lat), 32'd16);
    check_verdict0("sa0", 1'b0, 4'd2, 8'h90, 1'b1, 3'd4);
    repeat (3) @(negedge clk);
    check_verdict0("sa0_hold", 1'b0, 4'd2, 8'h90, 1'b1, 3'd4);

    // Stuck at 1
    mode = 2;
    run(0, 1'b0, lat, ok);
    check("sa1_lat", 32'(lat), 32'd16);
    check_verdict0("sa1", 1'b0, 4'd6, 8'h6F, 1'b1, 3'd0);

    // SETTLE=3 with correct circuit
    mode = 0;
    run(1, 1'b0, lat, ok);
    check("s3_lat",  32'(lat), 32'd32);
    check("s3_seq",  32'(ok), 32'd1);
    check("s3_pass", 32'(pass1), 32'd1);
    check("s3_err",  32'(err1), 32'd0);
    @(negedge clk);

    // start held high: back-to-back runs with one idle cycle between
    mode = 2;
    run(0, 1'b1, lat, ok);
    check("b2b_lat1", 32'(lat), 32'd16);
    check("b2b_seq1", 32'(ok), 32'd1);
    @(negedge clk);
    check("b2b_idle", 32'(busy0), 32'd0);
    @(negedge clk);
    check("b2b_rebusy", 32'(busy0), 32'd1);
    check("b2b_cleared", 32'(err0), 32'd0);
    mode = 0;
    lat  = -1;
    for (int n = 1; n < 100; n++) begin
      @(negedge clk);
      if (done0 === 1'b1) begin
        lat = n;
        break;
      end
    end
    start0 = 1'b0;
    check("b2b_lat2", 32'(lat), 32'd16);
    check("b2b_pass2", 32'(pass0), 32'd1);
    repeat (2) @(negedge clk);

    // Reset during vector 5 of a stuck-at-0 run
    mode = 1;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_vec5", 32'({a0, b0, c0}), 32'd5);
    check("mid_err_before", 32'(err0), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_busy", 32'(busy0), 32'd0);
    check("mid_done", 32'(done0), 32'd0);
    check("mid_vec",  32'({a0, b0, c0}), 32'd0);
    check_verdict0("mid", 1'b0, 4'd0, 8'h00, 1'b0, 3'd0);
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done0 !== 1'b0 || busy0 !== 1'b0) quiet = 1'b0;
    end
    check("mid_no_done", 32'(quiet), 32'd1);
    run(0, 1'b0, lat, ok);
    check("mid_rerun_lat", 32'(lat), 32'd16);
    check_verdict0("mid_rerun", 1'b0, 4'd2, 8'h90, 1'b1, 3'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
